// File: rtl/bypass_rf_commit_ctrl.sv
// Writeback arbiter onto the two RF write ports plus an in-order free sequencer.
// Define RF_ARB_FIXED_PRIORITY_EN for fixed lowest-index-first arbitration instead of round-robin.
module bypass_rf_commit_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int NAME_W  = 2,
    parameter int DATA_W  = 32
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          REQ_VALID,
    input  logic [NUM_REQ*NAME_W-1:0]   REQ_NAME,
    input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]          REQ_GRANT,
    output logic                        WE_1,
    output logic                        WE_2,
    output logic [NAME_W-1:0]           NAME_IN_1,
    output logic [NAME_W-1:0]           NAME_IN_2,
    output logic [DATA_W-1:0]           D_IN_1,
    output logic [DATA_W-1:0]           D_IN_2,
    input  logic                        FREE_VALID,
    input  logic [NAME_W-1:0]           FREE_NAME,
    output logic                        FREE_READY,
    output logic [NAME_W-1:0]           W_F,
    output logic                        WFE,
    input  logic                        F_READY,
    output logic [NAME_W:0]             PEND_CNT
);

    localparam int          PTR_W   = $clog2(NUM_REQ);
    localparam int          NUM_ENT = 2**NAME_W;
    localparam int unsigned NREQ_U  = NUM_REQ;

    logic [NAME_W-1:0]  w_name [NUM_REQ];
    logic [DATA_W-1:0]  w_data [NUM_REQ];
    logic [NUM_REQ-1:0] w_req_hit;
    logic [PTR_W-1:0]   w_start;
    logic [PTR_W-1:0]   w_idx;
    logic               w_s1_vld;
    logic               w_s2_vld;
    logic [PTR_W-1:0]   w_s1_idx;
    logic [PTR_W-1:0]   w_s2_idx;
    logic [NAME_W-1:0]  w_s1_name;
    logic               w_hazard;
    logic               w_accept;
    logic               w_issue;
    logic [NUM_ENT-1:0] r_pend;
    logic [NAME_W-1:0]  r_own;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_name[g]    = REQ_NAME[g*NAME_W +: NAME_W];
        assign w_data[g]    = REQ_DATA[g*DATA_W +: DATA_W];
        assign w_req_hit[g] = REQ_VALID[g] & (w_name[g] == r_own);
    end

`ifdef RF_ARB_FIXED_PRIORITY_EN
    assign w_start = '0;
`else
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_last_idx;

    assign w_start    = r_rr_ptr;
    assign w_last_idx = w_s2_vld ? w_s2_idx : w_s1_idx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rr_ptr <= '0;
        end else if (w_s1_vld) begin
            r_rr_ptr <= (w_last_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_last_idx + 1'b1;
        end
    end
`endif

    // Slot 2 skips requesters sharing slot 1's name; they retry next cycle.
    always_comb begin
        w_s1_vld  = 1'b0;
        w_s2_vld  = 1'b0;
        w_s1_idx  = '0;
        w_s2_idx  = '0;
        w_s1_name = '0;
        w_idx     = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            w_idx = PTR_W'((32'(w_start) + k) % NREQ_U);
            if (REQ_VALID[w_idx]) begin
                if (!w_s1_vld) begin
                    w_s1_vld  = 1'b1;
                    w_s1_idx  = w_idx;
                    w_s1_name = w_name[w_idx];
                end else if (!w_s2_vld && (w_name[w_idx] != w_s1_name)) begin
                    w_s2_vld = 1'b1;
                    w_s2_idx = w_idx;
                end
            end
        end
    end

    always_comb begin
        REQ_GRANT = '0;
        if (!RST) begin
            if (w_s1_vld) REQ_GRANT[w_s1_idx] = 1'b1;
            if (w_s2_vld) REQ_GRANT[w_s2_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            WE_1      <= 1'b0;
            WE_2      <= 1'b0;
            NAME_IN_1 <= '0;
            NAME_IN_2 <= '0;
            D_IN_1    <= '0;
            D_IN_2    <= '0;
        end else begin
            WE_1 <= w_s1_vld;
            WE_2 <= w_s2_vld;
            if (w_s1_vld) begin
                NAME_IN_1 <= w_name[w_s1_idx];
                D_IN_1    <= w_data[w_s1_idx];
            end
            if (w_s2_vld) begin
                NAME_IN_2 <= w_name[w_s2_idx];
                D_IN_2    <= w_data[w_s2_idx];
            end
        end
    end

    // A free must wait until every write to that entry has reached the RF.
    assign w_hazard   = (|w_req_hit) || (WE_1 && (NAME_IN_1 == r_own)) || (WE_2 && (NAME_IN_2 == r_own));
    assign FREE_READY = ~r_pend[FREE_NAME];
    assign W_F        = r_own;
    assign WFE        = ~RST & r_pend[r_own] & ~w_hazard;
    assign w_accept   = FREE_VALID & FREE_READY;
    assign w_issue    = WFE & F_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pend   <= '0;
            r_own    <= '0;
            PEND_CNT <= '0;
        end else begin
            if (w_accept) r_pend[FREE_NAME] <= 1'b1;
            if (w_issue) begin
                r_pend[r_own] <= 1'b0;
                r_own         <= r_own + 1'b1;
            end
            case ({w_accept, w_issue})
                2'b10:   PEND_CNT <= PEND_CNT + 1'b1;
                2'b01:   PEND_CNT <= PEND_CNT - 1'b1;
                default: PEND_CNT <= PEND_CNT;
            endcase
        end
    end

endmodule

// File: tb/tb_bypass_rf_commit_ctrl.sv
// Randomized scoreboard bench for bypass_rf_commit_ctrl against a request/pending-set reference model.
module tb_bypass_rf_commit_ctrl;

    localparam int NR   = 4;
    localparam int NW   = 2;
    localparam int DW   = 32;
    localparam int NENT = 4;
    localparam int NCYC = 1500;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [NR-1:0]    REQ_VALID = '0;
    logic [NR*NW-1:0] REQ_NAME = '0;
    logic [NR*DW-1:0] REQ_DATA = '0;
    logic [NR-1:0]    REQ_GRANT;
    logic             WE_1, WE_2;
    logic [NW-1:0]    NAME_IN_1, NAME_IN_2;
    logic [DW-1:0]    D_IN_1, D_IN_2;
    logic             FREE_VALID = 1'b0;
    logic [NW-1:0]    FREE_NAME = '0;
    logic             FREE_READY;
    logic [NW-1:0]    W_F;
    logic             WFE;
    logic             F_READY = 1'b0;
    logic [NW:0]      PEND_CNT;

    bypass_rf_commit_ctrl #(.NUM_REQ(NR), .NAME_W(NW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_NAME(REQ_NAME), .REQ_DATA(REQ_DATA), .REQ_GRANT(REQ_GRANT),
        .WE_1(WE_1), .WE_2(WE_2), .NAME_IN_1(NAME_IN_1), .NAME_IN_2(NAME_IN_2),
        .D_IN_1(D_IN_1), .D_IN_2(D_IN_2),
        .FREE_VALID(FREE_VALID), .FREE_NAME(FREE_NAME), .FREE_READY(FREE_READY),
        .W_F(W_F), .WFE(WFE), .F_READY(F_READY), .PEND_CNT(PEND_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NR-1:0] grant;
        logic          wfe;
        logic [NW-1:0] wf;
        logic          fr;
        logic          we1, we2;
        logic          c1, c2;
        logic [NW-1:0] n1, n2;
        logic [DW-1:0] d1, d2;
        logic [NW:0]   cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the oldest queued expectation each cycle.
    initial begin
        forever begin
            exp_t e;
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("REQ_GRANT", 64'(REQ_GRANT), 64'(e.grant));
                chk("WFE", 64'(WFE), 64'(e.wfe));
                chk("W_F", 64'(W_F), 64'(e.wf));
                chk("FREE_READY", 64'(FREE_READY), 64'(e.fr));
                chk("WE_1", 64'(WE_1), 64'(e.we1));
                chk("WE_2", 64'(WE_2), 64'(e.we2));
                chk("PEND_CNT", 64'(PEND_CNT), 64'(e.cnt));
                if (e.c1) begin
                    chk("NAME_IN_1", 64'(NAME_IN_1), 64'(e.n1));
                    chk("D_IN_1", 64'(D_IN_1), 64'(e.d1));
                end
                if (e.c2) begin
                    chk("NAME_IN_2", 64'(NAME_IN_2), 64'(e.n2));
                    chk("D_IN_2", 64'(D_IN_2), 64'(e.d2));
                end
            end
        end
    end

    // Reference model state: outstanding requests, last-cycle writes, pending set.
    bit            rq_v [NR];
    logic [NW-1:0] rq_n [NR];
    logic [DW-1:0] rq_d [NR];
    int            m_rr = 0;
    bit            m_pend [NENT];
    int            m_own = 0;
    bit            m_we1 = 0, m_we2 = 0, m_after_rst = 1;
    logic [NW-1:0] m_n1 = '0, m_n2 = '0;
    logic [DW-1:0] m_d1 = '0, m_d2 = '0;

    initial begin
        for (int i = 0; i < NR; i++) begin
            rq_v[i] = 0; rq_n[i] = '0; rq_d[i] = '0;
        end
        for (int i = 0; i < NENT; i++) m_pend[i] = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            exp_t e;
            int s1, s2, start, cnt;
            bit hz, acc, iss;
            @(posedge CLK);
            #2;
            RST = (cyc < 3) || (cyc == 500) || (cyc == 501);

            if (cyc == 3) begin
                for (int i = 0; i < NR; i++) begin
                    rq_v[i] = 1; rq_n[i] = NW'(i); rq_d[i] = 32'hA000_0000 + 32'(i);
                end
            end else if (cyc > 3) begin
                for (int i = 0; i < NR; i++) begin
                    if (!rq_v[i] && ($urandom_range(0, (cyc >= 800 && cyc < 1000) ? 7 : 2) == 0)) begin
                        rq_v[i] = 1; rq_n[i] = NW'($urandom_range(0, NENT-1)); rq_d[i] = $urandom;
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                REQ_VALID[i] = rq_v[i];
                REQ_NAME[i*NW +: NW] = rq_n[i];
                REQ_DATA[i*DW +: DW] = rq_d[i];
            end
            FREE_VALID = ($urandom_range(0, 2) != 0);
            FREE_NAME  = NW'($urandom_range(0, NENT-1));
            F_READY    = (cyc >= 300 && cyc < 380) ? 1'b0 : ($urandom_range(0, 3) != 0);

`ifdef RF_ARB_FIXED_PRIORITY_EN
            start = 0;
`else
            start = m_rr;
`endif
            s1 = -1; s2 = -1;
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (start + k) % NR;
                if (rq_v[i]) begin
                    if (s1 < 0) s1 = i;
                    else if (s2 < 0 && rq_n[i] != rq_n[s1]) s2 = i;
                end
            end
            hz = (m_we1 && m_n1 == NW'(m_own)) || (m_we2 && m_n2 == NW'(m_own));
            for (int i = 0; i < NR; i++) if (rq_v[i] && rq_n[i] == NW'(m_own)) hz = 1;
            cnt = 0;
            for (int i = 0; i < NENT; i++) cnt += int'(m_pend[i]);

            e.grant = '0;
            if (!RST) begin
                if (s1 >= 0) e.grant[s1] = 1'b1;
                if (s2 >= 0) e.grant[s2] = 1'b1;
            end
            e.wfe = !RST && m_pend[m_own] && !hz;
            e.wf  = NW'(m_own);
            e.fr  = !m_pend[FREE_NAME];
            e.we1 = m_we1; e.we2 = m_we2;
            e.c1  = m_we1 || m_after_rst;
            e.c2  = m_we2 || m_after_rst;
            e.n1  = m_n1; e.n2 = m_n2; e.d1 = m_d1; e.d2 = m_d2;
            e.cnt = (NW+1)'(cnt);
            q.push_back(e);

            if (RST) begin
                m_we1 = 0; m_we2 = 0; m_n1 = '0; m_n2 = '0; m_d1 = '0; m_d2 = '0;
                m_rr = 0; m_own = 0; m_after_rst = 1;
                for (int i = 0; i < NENT; i++) m_pend[i] = 0;
            end else begin
                m_after_rst = 0;
                acc = FREE_VALID && !m_pend[FREE_NAME];
                iss = e.wfe && F_READY;
                m_we1 = (s1 >= 0); m_we2 = (s2 >= 0);
                if (s1 >= 0) begin m_n1 = rq_n[s1]; m_d1 = rq_d[s1]; rq_v[s1] = 0; end
                if (s2 >= 0) begin m_n2 = rq_n[s2]; m_d2 = rq_d[s2]; rq_v[s2] = 0; end
                if (s2 >= 0) m_rr = (s2 + 1) % NR;
                else if (s1 >= 0) m_rr = (s1 + 1) % NR;
                if (acc) m_pend[FREE_NAME] = 1;
                if (iss) begin
                    m_pend[m_own] = 0;
                    m_own = (m_own + 1) % NENT;
                end
            end
        end

        @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
